// File: rtl/cache_frontend_if.sv
// CPU request/response and cache-controller signals seen by the request stage.
// master: CPU plus controller side; slave: the cache_frontend itself.
`ifndef CACHE_T
`define CACHE_T 24
`endif
`ifndef CACHE_S
`define CACHE_S 4
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

interface cache_frontend_if #(
    parameter int TAG_WIDTH  = `CACHE_T,
    parameter int SET_WIDTH  = `CACHE_S,
    parameter int LINE_WIDTH = `CACHE_B
);
    logic                  req_valid;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  busy;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic                  cc_en;
    logic                  cc_write_en;
    logic [TAG_WIDTH-1:0]  cc_tag;
    logic [SET_WIDTH-1:0]  cc_idx;
    logic [LINE_WIDTH-1:0] cc_offset;
    logic [31:0]           cc_data;
    logic                  cc_hit;
    logic [31:0]           cc_out;
    logic                  stat_clear;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, cc_hit, cc_out, stat_clear,
        input  busy, resp_valid, resp_err, resp_rdata, cc_en, cc_write_en,
               cc_tag, cc_idx, cc_offset, cc_data, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, cc_hit, cc_out, stat_clear,
        output busy, resp_valid, resp_err, resp_rdata, cc_en, cc_write_en,
               cc_tag, cc_idx, cc_offset, cc_data, hit_count, miss_count
    );
endinterface

// File: rtl/cache_frontend.sv
// Latches one CPU load/store, holds the cache controller enabled until it hits, then responds.
// Latency: hit 2 cycles, miss 2 + miss cycles, misaligned 1; busy high blocks new requests.
`ifndef CACHE_T
`define CACHE_T 24
`endif
`ifndef CACHE_S
`define CACHE_S 4
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_frontend #(
    parameter int TAG_WIDTH  = `CACHE_T,
    parameter int SET_WIDTH  = `CACHE_S,
    parameter int LINE_WIDTH = `CACHE_B
) (
    input  logic               clk,
    input  logic               reset,
    cache_frontend_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        missed_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic        busy;
    logic        resp_valid;
    logic        cc_en;
    logic        lookup_done;

    assign lookup_done = (state_q == LOOKUP) && bus.cc_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = (bus.req_addr[1:0] != 2'b00) ? RESP : LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cc_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        resp_valid = 1'b0;
        cc_en      = 1'b0;
        case (state_q)
            LOOKUP: begin
                busy  = 1'b1;
                cc_en = 1'b1;
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch: only written in IDLE, so the controller sees stable fields for the whole lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            missed_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (state_q == IDLE) begin
            if (bus.req_valid) begin
                addr_q   <= bus.req_addr;
                write_q  <= bus.req_write;
                wdata_q  <= bus.req_wdata;
                missed_q <= 1'b0;
                err_q    <= (bus.req_addr[1:0] != 2'b00);
                rdata_q  <= '0;
            end
        end else if (state_q == LOOKUP) begin
            if (!bus.cc_hit) begin
                missed_q <= 1'b1;
            end else begin
                rdata_q <= write_q ? 32'd0 : bus.cc_out;
            end
        end
    end

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || bus.stat_clear) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (lookup_done) begin
            if (missed_q) begin
                if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
            end else begin
                if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_err    = err_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.cc_en       = cc_en;
    assign bus.cc_write_en = write_q;
    assign bus.cc_tag      = addr_q[31 -: TAG_WIDTH];
    assign bus.cc_idx      = addr_q[LINE_WIDTH +: SET_WIDTH];
    assign bus.cc_offset   = addr_q[LINE_WIDTH-1:0];
    assign bus.cc_data     = wdata_q;
    assign bus.hit_count   = hit_q;
    assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_cache_frontend.sv
// Bench for cache_frontend: directed scenarios plus random requests against a counting model.
module tb_cache_frontend;
    localparam int TW = 24;
    localparam int SW = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_frontend_if #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW)) bus();

    cache_frontend #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    // One full request: drives the controller model (misses cycles of cc_hit=0, then a hit).
    task automatic run_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int misses, input logic [31:0] rd, input bit hold, input bit clr);
        logic [31:0]    exp_rd;
        logic [TW-1:0]  e_tag;
        logic [SW-1:0]  e_idx;
        logic [LW-1:0]  e_off;
        e_tag = TW'(addr >> (LW + SW));
        e_idx = SW'((addr >> LW) % (32'd1 << SW));
        e_off = LW'(addr % (32'd1 << LW));
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy);
        end
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.cc_hit = 1'b0; bus.cc_out = rd;
        @(negedge clk);
        if (hold) bus.req_addr = ~addr;
        else      bus.req_valid = 1'b0;
        if (addr[1:0] != 2'b00) begin
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'd0 || bus.cc_en !== 1'b0) begin
                n_bad++;
                $display("FAIL err_resp: got v=%b e=%b d=%h en=%b want v=1 e=1 d=0 en=0",
                         bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.cc_en);
            end
        end else begin
            for (int i = 0; i <= misses; i++) begin
                n_cmp++;
                if (bus.cc_en !== 1'b1 || bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lookup_ctl cyc %0d: got en=%b busy=%b v=%b want 1 1 0",
                             i, bus.cc_en, bus.busy, bus.resp_valid);
                end
                n_cmp++;
                if (bus.cc_tag !== e_tag || bus.cc_idx !== e_idx || bus.cc_offset !== e_off ||
                    bus.cc_write_en !== wr || bus.cc_data !== wdata) begin
                    n_bad++;
                    $display("FAIL lookup_fields cyc %0d: got %h/%h/%h we=%b d=%h want %h/%h/%h we=%b d=%h",
                             i, bus.cc_tag, bus.cc_idx, bus.cc_offset, bus.cc_write_en, bus.cc_data,
                             e_tag, e_idx, e_off, wr, wdata);
                end
                if (hold) bus.req_addr = $urandom;
                bus.cc_hit = (i == misses);
                if (i == misses) bus.stat_clear = clr;
                @(negedge clk);
            end
            bus.cc_hit = 1'b0;
            bus.stat_clear = 1'b0;
            if (clr) begin
                m_hit = 32'd0; m_miss = 32'd0;
            end else if (misses > 0) begin
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            end else begin
                if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
            end
            exp_rd = wr ? 32'd0 : rd;
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp_rd ||
                bus.cc_en !== 1'b0 || bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL resp: got v=%b e=%b d=%h en=%b busy=%b want v=1 e=0 d=%h en=0 busy=1",
                         bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.cc_en, bus.busy, exp_rd);
            end
        end
        n_cmp++;
        if (bus.hit_count !== m_hit || bus.miss_count !== m_miss) begin
            n_bad++;
            $display("FAIL counters: got hit=%h miss=%h want hit=%h miss=%h",
                     bus.hit_count, bus.miss_count, m_hit, m_miss);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_resp: got v=%b busy=%b want 0 0", bus.resp_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.cc_hit = 1'b0; bus.cc_out = '0; bus.stat_clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd0 ||
            bus.cc_en !== 1'b0 || bus.cc_write_en !== 1'b0 || bus.cc_tag !== '0 || bus.cc_idx !== '0 ||
            bus.cc_offset !== '0 || bus.cc_data !== 32'd0 || bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b v=%b en=%b tag=%h data=%h hit=%h miss=%h want all 0",
                     bus.busy, bus.resp_valid, bus.cc_en, bus.cc_tag, bus.cc_data, bus.hit_count, bus.miss_count);
        end
        reset = 1'b0;
        m_hit = 32'd0; m_miss = 32'd0;
    endtask

    task automatic test_directed();
        run_req(32'h0000_0040, 1'b0, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_req(32'h0000_0044, 1'b1, 32'h1234_5678, 5, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_req(32'h0000_0042, 1'b0, 32'd0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    endtask

    task automatic test_hold_valid();
        run_req(32'hA5A5_0120, 1'b0, 32'd0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
        run_req(32'h1357_9BD0, 1'b1, 32'h7777_1111, 0, 32'h3333_4444, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_lookup();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'hFEDC_BA90;
        bus.cc_hit = 1'b0; bus.cc_out = 32'h1111_2222;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hit = 32'd0; m_miss = 32'd0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.cc_en !== 1'b0 || bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0 ||
            bus.cc_tag !== '0 || bus.resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got busy=%b en=%b hit=%h miss=%h tag=%h v=%b want all 0",
                     bus.busy, bus.cc_en, bus.hit_count, bus.miss_count, bus.cc_tag, bus.resp_valid);
        end
        bus.cc_hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_quiet cyc %0d: got v=%b busy=%b want 0 0", i, bus.resp_valid, bus.busy);
            end
        end
        bus.cc_hit = 1'b0;
    endtask

    task automatic test_saturation();
        run_req(32'h0000_0100, 1'b0, 32'd0, 1, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        force dut.hit_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_q;
        m_hit = 32'hFFFF_FFFF;
        run_req(32'h0000_0200, 1'b0, 32'd0, 0, 32'h0000_0002, 1'b0, 1'b0);
        run_req(32'h0000_0300, 1'b0, 32'd0, 0, 32'h0000_0003, 1'b0, 1'b1);
        run_req(32'h0000_0400, 1'b0, 32'd0, 0, 32'h0000_0004, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_req(addr, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4), $urandom,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_valid();
        test_reset_mid_lookup();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
